// File: rtl/biriscv_mem_resp_pkg.sv
// Shared size codes, exception codes and FSM encoding for the biriscv load/store response path.
package biriscv_mem_resp_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [5:0] EXC_MISALIGNED_LOAD  = 6'h14;
  localparam logic [5:0] EXC_FAULT_LOAD       = 6'h15;
  localparam logic [5:0] EXC_MISALIGNED_STORE = 6'h16;
  localparam logic [5:0] EXC_FAULT_STORE      = 6'h17;

  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} lsu_size_e;

  typedef struct packed {
    lsu_size_e size;
    logic      sign;
  } lsu_fmt_t;

  // state | meaning
  // IDLE  | no access | REQ   | request on the bus, waiting for accept
  // WAIT  | accepted, waiting for ack | MISAL | misaligned access reporting its exception
  // DRAIN | squashed access, swallowing its ack
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_MISAL = 3'd3,
    ST_DRAIN = 3'd4
  } lsu_state_e;

  function automatic lsu_fmt_t decode_fmt(input logic [2:0] funct3);
    lsu_fmt_t f;
    f.size = SZ_W;
    f.sign = 1'b0;
    case (funct3)
      F3_LB:  begin f.size = SZ_B; f.sign = 1'b1; end
      F3_LH:  begin f.size = SZ_H; f.sign = 1'b1; end
      F3_LW:  f.size = SZ_W;
      F3_LBU: f.size = SZ_B;
      F3_LHU: f.size = SZ_H;
      default: f.size = SZ_W;
    endcase
    return f;
  endfunction

  function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] lo);
    return ((size == SZ_H) && lo[0]) || ((size == SZ_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/biriscv_lsu_align.sv
// Load lane extraction with sign/zero extension, and store lane replication with byte strobes.
module biriscv_lsu_align
  import biriscv_mem_resp_pkg::*;
(
  input  logic [31:0] rd_data_i,
  input  logic [1:0]  rd_offset_i,
  input  lsu_size_e   rd_size_i,
  input  logic        rd_sign_i,
  output logic [31:0] rd_result_o,
  input  logic [31:0] wr_data_i,
  input  logic [1:0]  wr_offset_i,
  input  lsu_size_e   wr_size_i,
  output logic [31:0] wr_data_o,
  output logic [3:0]  wr_strb_o
);

  logic [31:0] rd_shift;

  assign rd_shift = rd_data_i >> {rd_offset_i, 3'b000};

  always_comb begin
    case (rd_size_i)
      SZ_B:    rd_result_o = {{24{rd_sign_i & rd_shift[7]}}, rd_shift[7:0]};
      SZ_H:    rd_result_o = {{16{rd_sign_i & rd_shift[15]}}, rd_shift[15:0]};
      default: rd_result_o = rd_shift;
    endcase
  end

  always_comb begin
    case (wr_size_i)
      SZ_B: begin
        wr_data_o = {4{wr_data_i[7:0]}};
        wr_strb_o = 4'b0001 << wr_offset_i;
      end
      SZ_H: begin
        wr_data_o = {2{wr_data_i[15:0]}};
        wr_strb_o = 4'b0011 << {wr_offset_i[1], 1'b0};
      end
      default: begin
        wr_data_o = wr_data_i;
        wr_strb_o = 4'hF;
      end
    endcase
  end

endmodule

// File: rtl/biriscv_mem_resp.sv
// biriscv_mem_resp: E1/E2 load/store unit driving a single-outstanding data-memory request.
// The alignment check and MISAL state exist only when BIRISCV_LSU_MISALIGN_EN is defined.
module biriscv_mem_resp
  import biriscv_mem_resp_pkg::*;
#(
  parameter int unsigned SUPPORT_MISALIGN_CHECK = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_e1_i,
  input  logic        store_e1_i,
  input  logic [31:0] opcode_e1_i,
  input  logic [31:0] operand_ra_e1_i,
  input  logic [31:0] operand_rb_e1_i,
  input  logic        stall_i,
  input  logic        squash_i,
  output logic        mem_complete_o,
  output logic [31:0] mem_result_e2_o,
  output logic [5:0]  mem_exception_e2_o,
  output logic        lsu_busy_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_wr_o,
  output logic        mem_rd_o,
  output logic [3:0]  mem_wr_o,
  input  logic        mem_accept_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_rd_i,
  input  logic        mem_error_i
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        mem_rd_q, mem_rd_d;
  logic [3:0]  mem_wr_q, mem_wr_d;
  lsu_size_e   size_q, size_d;
  logic        sign_q, sign_d;
  logic        store_q, store_d;
  logic [1:0]  offset_q, offset_d;

  logic [11:0] imm_e1;
  logic [31:0] addr_e1;
  lsu_fmt_t    fmt_e1;
  logic [1:0]  offset_e1;
  logic        misal_e1;
  logic        access_e1;
  logic        issue_e1;
  logic [31:0] wr_data_e1;
  logic [3:0]  wr_strb_e1;
  logic [31:0] rd_result;
  logic        unused_ok;

  assign imm_e1    = store_e1_i ? {opcode_e1_i[31:25], opcode_e1_i[11:7]} : opcode_e1_i[31:20];
  assign addr_e1   = operand_ra_e1_i + {{20{imm_e1[11]}}, imm_e1};
  assign fmt_e1    = decode_fmt(opcode_e1_i[14:12]);
  assign access_e1 = (load_e1_i | store_e1_i) & ~stall_i & ~squash_i;

  // Lane offset is truncated to the access size, so unchecked misaligned accesses stay in-lane.
  always_comb begin
    case (fmt_e1.size)
      SZ_B:    offset_e1 = addr_e1[1:0];
      SZ_H:    offset_e1 = {addr_e1[1], 1'b0};
      default: offset_e1 = 2'b00;
    endcase
  end

`ifdef BIRISCV_LSU_MISALIGN_EN
  assign misal_e1  = (SUPPORT_MISALIGN_CHECK != 0) && is_misaligned(fmt_e1.size, addr_e1[1:0]);
  assign unused_ok = ^{opcode_e1_i[19:15], opcode_e1_i[6:0]};
`else
  assign misal_e1  = 1'b0;
  assign unused_ok = ^{opcode_e1_i[19:15], opcode_e1_i[6:0], (SUPPORT_MISALIGN_CHECK != 0)};
`endif

  biriscv_lsu_align u_align (
    .rd_data_i   (mem_data_rd_i),
    .rd_offset_i (offset_q),
    .rd_size_i   (size_q),
    .rd_sign_i   (sign_q),
    .rd_result_o (rd_result),
    .wr_data_i   (operand_rb_e1_i),
    .wr_offset_i (offset_e1),
    .wr_size_i   (fmt_e1.size),
    .wr_data_o   (wr_data_e1),
    .wr_strb_o   (wr_strb_e1)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mem_rd_d = mem_rd_q;
    mem_wr_d = mem_wr_q;
    size_d   = size_q;
    sign_d   = sign_q;
    store_d  = store_q;
    offset_d = offset_q;
    issue_e1 = 1'b0;

    case (state_q)
      ST_IDLE: issue_e1 = access_e1;
      ST_REQ: begin
        if (mem_accept_i) begin
          mem_rd_d = 1'b0;
          mem_wr_d = 4'h0;
          state_d  = squash_i ? ST_DRAIN : ST_WAIT;
        end else if (squash_i) begin
          mem_rd_d = 1'b0;
          mem_wr_d = 4'h0;
          state_d  = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (mem_ack_i) begin
          state_d  = ST_IDLE;
          issue_e1 = access_e1;
        end else if (squash_i) begin
          state_d = ST_DRAIN;
        end
      end
`ifdef BIRISCV_LSU_MISALIGN_EN
      ST_MISAL: begin
        state_d  = ST_IDLE;
        issue_e1 = access_e1;
      end
`endif
      ST_DRAIN: if (mem_ack_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (issue_e1) begin
      state_d  = misal_e1 ? ST_MISAL : ST_REQ;
      addr_d   = {addr_e1[31:2], 2'b00};
      wdata_d  = store_e1_i ? wr_data_e1 : 32'h0;
      mem_rd_d = ~store_e1_i & ~misal_e1;
      mem_wr_d = (store_e1_i & ~misal_e1) ? wr_strb_e1 : 4'h0;
      size_d   = fmt_e1.size;
      sign_d   = fmt_e1.sign;
      store_d  = store_e1_i;
      offset_d = offset_e1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 4'h0;
      size_q   <= SZ_B;
      sign_q   <= 1'b0;
      store_q  <= 1'b0;
      offset_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      size_q   <= size_d;
      sign_q   <= sign_d;
      store_q  <= store_d;
      offset_q <= offset_d;
    end
  end

  // Completion, data and exception are combinational from the ack so loads add no latency.
  always_comb begin
    mem_complete_o     = 1'b0;
    mem_result_e2_o    = 32'h0;
    mem_exception_e2_o = 6'h0;
    if ((state_q == ST_WAIT) && mem_ack_i) begin
      mem_complete_o = 1'b1;
      if (mem_error_i) begin
        mem_exception_e2_o = store_q ? EXC_FAULT_STORE : EXC_FAULT_LOAD;
      end else if (!store_q) begin
        mem_result_e2_o = rd_result;
      end
    end
`ifdef BIRISCV_LSU_MISALIGN_EN
    if (state_q == ST_MISAL) begin
      mem_complete_o     = 1'b1;
      mem_exception_e2_o = store_q ? EXC_MISALIGNED_STORE : EXC_MISALIGNED_LOAD;
    end
`endif
  end

  assign lsu_busy_o    = (state_q == ST_DRAIN);
  assign mem_addr_o    = addr_q;
  assign mem_data_wr_o = wdata_q;
  assign mem_rd_o      = mem_rd_q;
  assign mem_wr_o      = mem_wr_q;

endmodule
